cnn_frame_scheduler: RTL and testbench
======================================

Name: cnn_frame_scheduler

Overview:
- Sequences multi-frame inference on the CNN top.
- Accepts a valid/ready stream of 12-bit input words and drives the input Memory write port (write_en/count/pins) in fixed COUNT_MAX-word bursts on a fixed ITER_MAX-cycle frame period.
- Holds CNN en for the whole job, tallies CNN valid results against the requested frame count, and signals done or error.
- Replaces hand-timed stimulus sequencing with a reusable on-chip controller.

Parameters:
- COUNT_MAX, 200: input words per frame; must be ≤ 256.
- ITER_MAX, 288: frame period in cycles; must be > COUNT_MAX.
- DISCARD_FIRST, 1: leading cnn_valid pulses per job that are pipeline-fill and not reported.
- DRAIN_MAX, 4000: cycles allowed after the last frame for the remaining results to arrive.
- FRAME_W, 16: width of frame counters.

Ports:
- clk  in  1  clock.
- rst_b  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job start; ignored while busy.
- num_frames  in  FRAME_W  frames in job; sampled on accepted start.
- in_valid  in  1  input word valid.
- in_data  in  12  input word; bit 11 maps to pin0, bit 0 to pin11.
- in_ready  out  1  word accepted when in_valid && in_ready.
- write_en  out  1  Memory write enable.
- count  out  8  Memory word address.
- pins  out  12  Memory pin0..pin11, same mapping as in_data.
- cnn_en  out  1  CNN enable.
- cnn_valid  in  1  CNN result strobe.
- result_valid  out  1  a reported (non-discarded) result this cycle.
- result_idx  out  FRAME_W  index of the reported result, from 0.
- frame_idx  out  FRAME_W  frame currently loading.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end.
- err_underrun  out  1  sticky flag.
- err_timeout  out  1  sticky flag.

Behaviour:
- Reset: every output is 0 and the state is IDLE. Reset mid-job abandons the job; no done pulse is issued.
- Frame timer t runs 0..ITER_MAX-1 and advances every cycle once a frame starts.
- States:
  - IDLE: in_ready=0, cnn_en=0. On start:
    - num_frames==0: pulse done the next cycle and stay IDLE.
    - Otherwise: latch num_frames; clear both error flags, frame_idx, result_idx and the discard counter; set busy=1 and cnn_en=1; go to WAIT.
  - WAIT (t=0): in_ready=1. On the first accepted word, register write_en=1, count=0, pins=in_data, then go to LOAD with t=1.
  - LOAD (1 ≤ t < COUNT_MAX): in_ready=1.
    - Word accepted: write_en=1, count=t, pins=in_data.
    - in_valid=0: write_en=0, count=t, pins hold; set err_underrun. The slot is skipped; t still advances.
    - At t=COUNT_MAX-1 go to GAP.
  - GAP (COUNT_MAX ≤ t < ITER_MAX): in_ready=0, write_en=0. At t=ITER_MAX-1:
    - frame_idx+1 < num_frames: frame_idx++ and go to WAIT. Back-to-back frames therefore have a period of exactly ITER_MAX when data is ready.
    - Otherwise: go to DRAIN with the drain timer at 0.
  - DRAIN: the drain timer counts every cycle.
    - Reported results == num_frames: go to DONE.
    - Drain timer == DRAIN_MAX-1: set err_timeout and go to DONE.
  - DONE: one cycle with done=1; busy, cnn_en and in_ready go to 0. Next state IDLE.
- Memory outputs are registered, so there is 1 cycle of latency from an in_data handshake to write_en/pins.
- Result counting is active in every state while cnn_en=1:
  - The first DISCARD_FIRST cnn_valid pulses only increment the discard counter.
  - Each later pulse gives result_valid=1 in the same cycle (combinational from the registered discard state), with result_idx showing the current count; result_idx increments on the next edge.
  - cnn_valid while cnn_en=0 is ignored.
- Boundaries:
  - start while busy has no effect.
  - A result arriving in the same cycle as the DRAIN completion check counts before the check. Completion is evaluated on next-state, so done follows the final result by 1 cycle.
  - cnn_valid beyond num_frames reported results during the job is still reported; result_idx saturates at all-ones.

Decomposition:
- Shared package cnn_sched_pkg holds:
  - The state enum: IDLE, WAIT, LOAD, GAP, DRAIN, DONE.
  - Default constants: COUNT_MAX=200, ITER_MAX=288, PIN_W=12.
  - Function cnt_w(n), returning the counter width.
- One natural sub-module: cnn_result_tracker (discard counter, result_idx, result_valid), instantiated once.

Test Plan:
- start with num_frames=1, 200 words streamed with no stalls, cnn_valid pulsed twice:
  - write_en high for exactly 200 consecutive cycles, count 0..199, pins match the words.
  - First pulse discarded; second gives result_valid with result_idx=0.
  - done 1 cycle after the second pulse.
- num_frames=3 with continuous data: the first write of each frame occurs at cycles T, T+288, T+576; frame_idx reads 0,1,2.
- in_valid dropped at t=50 for one cycle: write_en=0 with count=50 that cycle; err_underrun=1 and remains 1 until the next start.
- No cnn_valid after the last frame: err_timeout=1 and done pulses exactly 4000 cycles after DRAIN entry.
- rst_b asserted at t=120 of frame 1: the next cycle all outputs are 0 and the state is IDLE; a following start with num_frames=1 completes normally.
- Start with num_frames=0 → done pulse after 1 cycle, no write_en. A start pulse issued mid-job is ignored: frame_idx is unaffected.

Source files
------------

// File: rtl/cnn_sched_pkg.sv
// Shared definitions for the CNN frame scheduler.
//   sched_state_e : scheduler FSM states
//   *_DEF         : default frame geometry (words per frame, frame period)
//   PIN_W         : width of one Memory input word (pin0..pin11)
//   cnt_w(n)      : bits needed for a counter that holds 0..n-1
package cnn_sched_pkg;

    localparam int unsigned COUNT_MAX_DEF = 200;
    localparam int unsigned ITER_MAX_DEF  = 288;
    localparam int unsigned PIN_W         = 12;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StLoad,
        StGap,
        StDrain,
        StDone
    } sched_state_e;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cnn_result_tracker.sv
// Result tracker: drops the leading pipeline-fill strobes of a job and
// numbers the rest.
//   clk, rst_b      : clock, synchronous active-high reset
//   clear           : start of a new job, zeroes discard count and result_idx
//   active          : CNN enabled; strobes outside a job are ignored
//   cnn_valid       : CNN result strobe
//   result_valid    : reported (non-discarded) strobe this cycle
//   result_idx      : index of the reported result (saturates at all-ones)
//   result_cnt_next : number of reported results after this cycle
module cnn_result_tracker
    import cnn_sched_pkg::*;
#(
    parameter int unsigned DISCARD_FIRST = 1,
    parameter int unsigned FRAME_W       = 16
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               clear,
    input  logic               active,
    input  logic               cnn_valid,
    output logic               result_valid,
    output logic [FRAME_W-1:0] result_idx,
    output logic [FRAME_W-1:0] result_cnt_next
);

    localparam int unsigned DiscW = cnt_w(DISCARD_FIRST + 1);
    localparam logic [DiscW-1:0] DiscLast = DiscW'(DISCARD_FIRST);

    logic [DiscW-1:0]   disc_q, disc_d;
    logic [FRAME_W-1:0] idx_q, idx_d;
    logic               pulse;

    assign pulse        = active && cnn_valid;
    // Combinational from registered state so the index is visible in the strobe cycle.
    assign result_valid = pulse && (disc_q == DiscLast);

    always_comb begin
        disc_d = disc_q;
        idx_d  = idx_q;
        if (clear) begin
            disc_d = '0;
            idx_d  = '0;
        end else if (pulse) begin
            if (disc_q != DiscLast) begin
                disc_d = disc_q + 1'b1;
            end else if (idx_q != '1) begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            disc_q <= '0;
            idx_q  <= '0;
        end else begin
            disc_q <= disc_d;
            idx_q  <= idx_d;
        end
    end

    assign result_idx      = idx_q;
    assign result_cnt_next = idx_d;

endmodule

// File: rtl/cnn_frame_scheduler.sv
// CNN frame scheduler: streams COUNT_MAX input words per frame into the
// input Memory on a fixed ITER_MAX-cycle period, keeps the CNN enabled for
// the job, counts results and reports done / error.
//   clk, rst_b            : clock, synchronous active-high reset
//   start, num_frames     : job request (ignored while busy)
//   in_valid/in_data      : input word stream, in_ready accepts
//   write_en/count/pins   : registered Memory write port
//   cnn_en, cnn_valid     : CNN enable and result strobe
//   result_valid/idx      : reported result and its index
//   frame_idx, busy, done : progress, job in progress, end-of-job pulse
//   err_underrun/timeout  : sticky errors, cleared by the next accepted job
// COUNT_MAX must be <= 256 and ITER_MAX > COUNT_MAX.
module cnn_frame_scheduler
    import cnn_sched_pkg::*;
#(
    parameter int unsigned COUNT_MAX     = COUNT_MAX_DEF,
    parameter int unsigned ITER_MAX      = ITER_MAX_DEF,
    parameter int unsigned DISCARD_FIRST = 1,
    parameter int unsigned DRAIN_MAX     = 4000,
    parameter int unsigned FRAME_W       = 16
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               start,
    input  logic [FRAME_W-1:0] num_frames,
    input  logic               in_valid,
    input  logic [PIN_W-1:0]   in_data,
    output logic               in_ready,
    output logic               write_en,
    output logic [7:0]         count,
    output logic [PIN_W-1:0]   pins,
    output logic               cnn_en,
    input  logic               cnn_valid,
    output logic               result_valid,
    output logic [FRAME_W-1:0] result_idx,
    output logic [FRAME_W-1:0] frame_idx,
    output logic               busy,
    output logic               done,
    output logic               err_underrun,
    output logic               err_timeout
);

    localparam int unsigned TW = cnt_w(ITER_MAX);
    localparam int unsigned DW = cnt_w(DRAIN_MAX);
    localparam logic [TW-1:0] TLoadLast = TW'(COUNT_MAX - 1);
    localparam logic [TW-1:0] TGapLast  = TW'(ITER_MAX - 1);
    localparam logic [DW-1:0] DrainLast = DW'(DRAIN_MAX - 1);

    sched_state_e       state_q, state_d;
    logic [TW-1:0]      t_q, t_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic [FRAME_W-1:0] frames_q, frames_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               we_q, we_d;
    logic [7:0]         count_q, count_d;
    logic [PIN_W-1:0]   pins_q, pins_d;
    logic               busy_q, busy_d;
    logic               en_q, en_d;
    logic               done_q, done_d;
    logic               und_q, und_d;
    logic               tmo_q, tmo_d;
    logic               accept;
    logic               clear;
    logic [FRAME_W-1:0] result_cnt_next;

    assign in_ready = (state_q == StWait) || (state_q == StLoad);
    assign accept   = in_valid && in_ready;
    assign clear    = (state_q == StIdle) && start && (num_frames != '0);

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        drain_d  = drain_q;
        frames_d = frames_q;
        frame_d  = frame_q;
        we_d     = 1'b0;
        count_d  = count_q;
        pins_d   = pins_q;
        und_d    = und_q;
        tmo_d    = tmo_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (num_frames == '0) begin
                        done_d = 1'b1;
                    end else begin
                        frames_d = num_frames;
                        frame_d  = '0;
                        und_d    = 1'b0;
                        tmo_d    = 1'b0;
                        t_d      = '0;
                        state_d  = StWait;
                    end
                end
            end
            // Frame timer is held at 0 until the first word of the frame arrives.
            StWait: begin
                if (accept) begin
                    we_d    = 1'b1;
                    count_d = '0;
                    pins_d  = in_data;
                    t_d     = TW'(1);
                    state_d = StLoad;
                end
            end
            // One slot per cycle; a missing word skips its slot rather than stalling.
            StLoad: begin
                count_d = 8'(t_q);
                if (accept) begin
                    we_d   = 1'b1;
                    pins_d = in_data;
                end else begin
                    und_d = 1'b1;
                end
                t_d = t_q + 1'b1;
                if (t_q == TLoadLast) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (t_q == TGapLast) begin
                    t_d = '0;
                    if (frame_q + 1'b1 < frames_q) begin
                        frame_d = frame_q + 1'b1;
                        state_d = StWait;
                    end else begin
                        drain_d = '0;
                        state_d = StDrain;
                    end
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            // A result in this cycle counts before the timeout check.
            StDrain: begin
                drain_d = drain_q + 1'b1;
                if (result_cnt_next >= frames_q) begin
                    state_d = StDone;
                end else if (drain_q == DrainLast) begin
                    tmo_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_d == StDone) begin
            done_d = 1'b1;
        end
    end

    assign busy_d = (state_d != StIdle) && (state_d != StDone);
    assign en_d   = busy_d;

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q  <= StIdle;
            t_q      <= '0;
            drain_q  <= '0;
            frames_q <= '0;
            frame_q  <= '0;
            we_q     <= 1'b0;
            count_q  <= '0;
            pins_q   <= '0;
            busy_q   <= 1'b0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
            und_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            drain_q  <= drain_d;
            frames_q <= frames_d;
            frame_q  <= frame_d;
            we_q     <= we_d;
            count_q  <= count_d;
            pins_q   <= pins_d;
            busy_q   <= busy_d;
            en_q     <= en_d;
            done_q   <= done_d;
            und_q    <= und_d;
            tmo_q    <= tmo_d;
        end
    end

    cnn_result_tracker #(
        .DISCARD_FIRST(DISCARD_FIRST),
        .FRAME_W      (FRAME_W)
    ) u_tracker (
        .clk            (clk),
        .rst_b          (rst_b),
        .clear          (clear),
        .active         (en_q),
        .cnn_valid      (cnn_valid),
        .result_valid   (result_valid),
        .result_idx     (result_idx),
        .result_cnt_next(result_cnt_next)
    );

    assign write_en     = we_q;
    assign count        = count_q;
    assign pins         = pins_q;
    assign cnn_en       = en_q;
    assign frame_idx    = frame_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_underrun = und_q;
    assign err_timeout  = tmo_q;

endmodule

// File: tb/tb_cnn_frame_scheduler.sv
// Testbench for cnn_frame_scheduler: drives jobs, records expected Memory
// writes and results in queues, and compares them as the DUT produces them.
module tb_cnn_frame_scheduler;

    localparam int CountMax   = 200;
    localparam int IterMax    = 288;
    localparam int Discard    = 1;
    localparam int DrainMax   = 4000;
    localparam int WaitLimit  = 1000;
    localparam int DoneLimit  = 5000;

    typedef struct {
        int         due;
        logic       we;
        logic [7:0] cnt;
        logic [11:0] pins;
    } wr_exp_t;

    typedef struct {
        int          due;
        logic        rv;
        logic [15:0] idx;
    } res_exp_t;

    logic        clk;
    logic        rst_b;
    logic        start;
    logic [15:0] num_frames;
    logic        in_valid;
    logic [11:0] in_data;
    logic        in_ready;
    logic        write_en;
    logic [7:0]  count;
    logic [11:0] pins;
    logic        cnn_en;
    logic        cnn_valid;
    logic        result_valid;
    logic [15:0] result_idx;
    logic [15:0] frame_idx;
    logic        busy;
    logic        done;
    logic        err_underrun;
    logic        err_timeout;

    wr_exp_t     wq[$];
    res_exp_t    rq[$];
    int          runs[$];
    int          run_len;
    int          cyc;
    int          n_checks;
    int          n_errors;
    bit          mon_en;
    int          m_pulses;
    logic [11:0] last_pins;

    cnn_frame_scheduler #(
        .COUNT_MAX    (CountMax),
        .ITER_MAX     (IterMax),
        .DISCARD_FIRST(Discard),
        .DRAIN_MAX    (DrainMax),
        .FRAME_W      (16)
    ) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .start       (start),
        .num_frames  (num_frames),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .write_en    (write_en),
        .count       (count),
        .pins        (pins),
        .cnn_en      (cnn_en),
        .cnn_valid   (cnn_valid),
        .result_valid(result_valid),
        .result_idx  (result_idx),
        .frame_idx   (frame_idx),
        .busy        (busy),
        .done        (done),
        .err_underrun(err_underrun),
        .err_timeout (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [11:0] word(input int f, input int s);
        return 12'((f << 8) ^ (s * 13) ^ 32'h5a3);
    endfunction

    // Scoreboard consumer: every cycle either an expected entry is due or the
    // strobe must be low.
    initial begin
        wr_exp_t  we_e;
        res_exp_t re_e;
        run_len = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (wq.size() > 0 && wq[0].due == cyc) begin
                    we_e = wq.pop_front();
                    check("write_en", 32'(write_en), 32'(we_e.we));
                    check("count", 32'(count), 32'(we_e.cnt));
                    check("pins", 32'(pins), 32'(we_e.pins));
                end else begin
                    check("idle_write_en", 32'(write_en), 32'd0);
                end
                if (rq.size() > 0 && rq[0].due == cyc) begin
                    re_e = rq.pop_front();
                    check("result_valid", 32'(result_valid), 32'(re_e.rv));
                    if (re_e.rv) check("result_idx", 32'(result_idx), 32'(re_e.idx));
                end else begin
                    check("idle_result_valid", 32'(result_valid), 32'd0);
                end
                if (write_en) begin
                    run_len++;
                end else if (run_len > 0) begin
                    runs.push_back(run_len);
                    run_len = 0;
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_write_en"}, 32'(write_en), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_pins"}, 32'(pins), 32'd0);
        check({tag, "_cnn_en"}, 32'(cnn_en), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_result_valid"}, 32'(result_valid), 32'd0);
        check({tag, "_result_idx"}, 32'(result_idx), 32'd0);
        check({tag, "_frame_idx"}, 32'(frame_idx), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err_underrun"}, 32'(err_underrun), 32'd0);
        check({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
    endtask

    // Called at drive time; the strobe is compared in the same cycle.
    task automatic exp_pulse();
        res_exp_t r;
        r.due = cyc;
        r.rv  = (m_pulses >= Discard);
        r.idx = 16'(m_pulses - Discard);
        rq.push_back(r);
        m_pulses++;
    endtask

    task automatic pulse();
        cnn_valid = 1'b1;
        exp_pulse();
        @(posedge clk);
        #1;
        cnn_valid = 1'b0;
    endtask

    task automatic start_job(input int n);
        start      = 1'b1;
        num_frames = 16'(n);
        m_pulses   = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("job_busy", 32'(busy), 32'd1);
        check("job_cnn_en", 32'(cnn_en), 32'd1);
        check("job_in_ready", 32'(in_ready), 32'd1);
        check("job_err_underrun_clr", 32'(err_underrun), 32'd0);
        check("job_err_timeout_clr", 32'(err_timeout), 32'd0);
        check("job_frame_idx", 32'(frame_idx), 32'd0);
        check("job_result_idx", 32'(result_idx), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Streams one frame. hs_cyc is the cycle in which word 0 is handshaken.
    task automatic load_frame(input int f, input int drop_slot, input int abort_slot,
                              input int pulse_slot, input int start_slot,
                              output int hs_cyc);
        int      n;
        wr_exp_t e;
        hs_cyc = 0;
        for (int s = 0; s < CountMax; s++) begin
            if (s == abort_slot) begin
                rst_b     = 1'b1;
                in_valid  = 1'b0;
                cnn_valid = 1'b0;
                start     = 1'b0;
                @(posedge clk);
                #1;
                rst_b = 1'b0;
                @(negedge clk);
                check_all_zero("abort");
                wq.delete();
                rq.delete();
                runs.delete();
                @(posedge clk);
                #1;
                return;
            end
            in_valid  = (s != drop_slot);
            in_data   = word(f, s);
            cnn_valid = (s == pulse_slot);
            if (cnn_valid) exp_pulse();
            if (s == start_slot) begin
                start      = 1'b1;
                num_frames = 16'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (s == 0) begin
                n = 0;
                while (!in_ready && n < WaitLimit) begin
                    @(posedge clk);
                    #1;
                    @(negedge clk);
                    n++;
                end
                check("wait_in_ready", 32'(in_ready), 32'd1);
                check("frame_idx", 32'(frame_idx), 32'(f));
                hs_cyc = cyc;
            end else begin
                check("load_in_ready", 32'(in_ready), 32'd1);
            end
            if (start_slot >= 0 && s == start_slot + 1) begin
                check("mid_start_frame_idx", 32'(frame_idx), 32'(f));
                check("mid_start_busy", 32'(busy), 32'd1);
            end
            if (in_valid) last_pins = in_data;
            e = '{cyc + 1, in_valid, 8'(s), last_pins};
            wq.push_back(e);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        cnn_valid = 1'b0;
        start     = 1'b0;
    endtask

    // Ends at the negedge of the done cycle.
    task automatic wait_done(output int dcyc);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < DoneLimit) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("done_busy_low", 32'(busy), 32'd0);
        dcyc = cyc;
    endtask

    task automatic finish_job();
        @(posedge clk);
        #1;
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_cnn_en", 32'(cnn_en), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int h;
        int d;
        int p;
        int hs[3];

        n_checks   = 0;
        n_errors   = 0;
        mon_en     = 1'b0;
        rst_b      = 1'b1;
        start      = 1'b0;
        num_frames = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        cnn_valid  = 1'b0;
        m_pulses   = 0;
        last_pins  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_b = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Strobe while idle is ignored.
        cnn_valid = 1'b1;
        rq.push_back('{cyc, 1'b0, 16'd0});
        @(posedge clk);
        #1;
        cnn_valid = 1'b0;

        // Zero-frame job: done one cycle later, no writes.
        start      = 1'b1;
        num_frames = 16'd0;
        p          = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(d);
        check("zero_done_lat", 32'(d), 32'(p + 1));
        finish_job();

        // Single frame, continuous data, discard then one result in drain.
        start_job(1);
        load_frame(0, -1, -1, 10, -1, h);
        while (cyc < h + 300) begin
            @(posedge clk);
            #1;
        end
        p = cyc;
        pulse();
        wait_done(d);
        check("single_done_lat", 32'(d), 32'(p + 1));
        check("single_result_cnt", 32'(result_idx), 32'd1);
        check("single_runs", 32'(runs.size()), 32'd1);
        if (runs.size() > 0) check("single_run_len", 32'(runs[0]), 32'(CountMax));
        runs.delete();
        finish_job();

        // Three frames back to back; a start during frame 1 must be ignored.
        start_job(3);
        for (int f = 0; f < 3; f++) begin
            load_frame(f, -1, -1, 20, (f == 1) ? 30 : -1, hs[f]);
        end
        pulse();
        wait_done(d);
        check("multi_period_1", 32'(hs[1] - hs[0]), 32'(IterMax));
        check("multi_period_2", 32'(hs[2] - hs[1]), 32'(IterMax));
        check("multi_done_lat", 32'(d), 32'(hs[2] + IterMax + 1));
        check("multi_result_cnt", 32'(result_idx), 32'd3);
        check("multi_no_timeout", 32'(err_timeout), 32'd0);
        finish_job();

        // Missing word at slot 50, then no results: underrun and timeout.
        start_job(1);
        load_frame(0, 50, -1, -1, -1, h);
        @(negedge clk);
        check("underrun_set", 32'(err_underrun), 32'd1);
        check("timeout_not_yet", 32'(err_timeout), 32'd0);
        @(posedge clk);
        #1;
        wait_done(d);
        check("timeout_done_lat", 32'(d), 32'(h + IterMax + DrainMax));
        check("timeout_flag", 32'(err_timeout), 32'd1);
        check("underrun_sticky", 32'(err_underrun), 32'd1);
        finish_job();
        @(negedge clk);
        check("underrun_sticky_idle", 32'(err_underrun), 32'd1);
        check("timeout_sticky_idle", 32'(err_timeout), 32'd1);
        @(posedge clk);
        #1;

        // Reset at t=120 of frame 1, then a normal single-frame job.
        start_job(3);
        load_frame(0, -1, -1, 20, -1, h);
        load_frame(1, -1, 120, -1, -1, h);
        start_job(1);
        load_frame(0, -1, -1, 10, -1, h);
        pulse();
        wait_done(d);
        check("after_reset_done_lat", 32'(d), 32'(h + IterMax + 1));
        check("after_reset_result_cnt", 32'(result_idx), 32'd1);
        finish_job();

        check("write_queue_empty", 32'(wq.size()), 32'd0);
        check("result_queue_empty", 32'(rq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
